rr_pkt_arb4: RTL and testbench

- Packet-aware round-robin arbiter that sits directly in front of the team's 4:1 data mux (mux4to1).
- Arbitrates four valid/ready sources and drives the mux `sel` combinationally.
- Captures the mux output (`mux_data`) into a one-entry registered output stage with valid/ready.
- Holds the grant on a source from its first beat until its `in_last` beat, so packets are never interleaved.

---
 rtl/rr_pkt_arb4.sv | 86 ++++++++
 tb/tb_rr_pkt_arb4.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rr_pkt_arb4.sv
// Packet-aware 4-source round-robin arbiter driving an external 4:1 mux; 1-cycle latency to a registered output beat.
// A beat is accepted only when the output stage is empty or draining; a packet holds its grant until its last beat.
module rr_pkt_arb4 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [3:0]       in_last,
  output logic [3:0]       in_ready,
  output logic [1:0]       sel,
  input  logic [WIDTH-1:0] mux_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       out_src
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] lock_src, lock_nxt;
  logic [1:0] cand, idx;
  logic       space, load;

  // Walk from ptr+3 down to ptr so the source closest to ptr wins.
  always_comb begin
    cand = ptr;
    idx  = ptr;
    if (state == LOCKED) begin
      cand = lock_src;
    end else begin
      for (int k = 3; k >= 0; k--) begin
        idx = ptr + 2'(k);
        if (in_valid[idx]) cand = idx;
      end
    end
  end

  assign sel      = cand;
  assign space    = !out_valid || out_ready;
  assign load     = space && in_valid[cand];
  assign in_ready = load ? (4'b0001 << cand) : 4'b0000;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    lock_nxt  = lock_src;
    if (load) begin
      if (in_last[cand]) begin
        state_nxt = IDLE;
        ptr_nxt   = cand + 2'd1;
      end else begin
        state_nxt = LOCKED;
        lock_nxt  = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      lock_src  <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 2'd0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      lock_src <= lock_nxt;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
        out_last  <= in_last[cand];
        out_src   <= cand;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_pkt_arb4.sv
// Directed bench for rr_pkt_arb4 with a behavioural 4:1 mux feeding mux_data from sel.
module tb_rr_pkt_arb4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic [31:0] mux_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [1:0]  out_src;
  logic [31:0] d [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign mux_data = d[sel];

  rr_pkt_arb4 #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .sel(sel), .mux_data(mux_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_src(out_src)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rr_exp [5];
    rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2; rr_exp[3] = 2'd3; rr_exp[4] = 2'd0;
    for (int i = 0; i < 4; i++) d[i] = 32'hA0 + 32'(i);

    // Reset with all sources requesting
    rst = 1'b1; in_valid = 4'b1111; in_last = 4'b0000; out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_src",   out_src,   0);
    check("rst_out_last",  out_last,  0);
    rst = 1'b0; in_valid = 4'b0000;
    #1;
    check("idle_in_ready", in_ready, 4'b0000);
    check("idle_sel",      sel,      0);
    tick();
    check("idle_out_valid", out_valid, 0);

    // Round-robin single-beat packets, wrap 3 -> 0
    in_valid = 4'b1111; in_last = 4'b1111;
    #1;
    check("rr_first_sel",   sel,      0);
    check("rr_first_ready", in_ready, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_out_valid", out_valid, 1);
      check("rr_out_src",   out_src,   32'(rr_exp[i]));
      check("rr_out_data",  out_data,  32'hA0 + 32'(rr_exp[i]));
      check("rr_out_last",  out_last,  1);
    end

    // Packet lock: source 1 sends 3 beats while source 2 waits (ptr=1)
    in_valid = 4'b0110; in_last = 4'b0000; d[1] = 32'hB1; d[2] = 32'hB2;
    #1;
    check("lock_b1_ready", in_ready, 4'b0010);
    tick();
    check("lock_b1_src",  out_src,  1);
    check("lock_b1_last", out_last, 0);
    check("lock_b2_ready", in_ready, 4'b0010);
    tick();
    check("lock_b2_src", out_src, 1);
    in_last = 4'b0110;
    #1;
    check("lock_b3_ready", in_ready, 4'b0010);
    tick();
    check("lock_b3_src",  out_src,  1);
    check("lock_b3_last", out_last, 1);
    check("lock_next_ready", in_ready, 4'b0100);
    tick();
    check("lock_next_src",  out_src,  2);
    check("lock_next_data", out_data, 32'hB2);

    // Backpressure (ptr=3, only source 0 valid)
    in_valid = 4'b0001; in_last = 4'b0001; d[0] = 32'h1234;
    tick();
    check("bp_load_data", out_data, 32'h1234);
    check("bp_load_src",  out_src,  0);
    out_ready = 1'b0; in_valid = 4'b0010; in_last = 4'b0010; d[1] = 32'h5678;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", in_ready, 4'b0000);
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data",  out_data,  32'h1234);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 4'b0010);
    tick();
    check("bp_release_data", out_data, 32'h5678);
    check("bp_release_src",  out_src,  1);

    // Locked stall on source 3 (ptr=2)
    in_valid = 4'b1000; in_last = 4'b0000; d[3] = 32'hC3;
    tick();
    check("stall_first_src",  out_src,  3);
    check("stall_first_last", out_last, 0);
    in_valid = 4'b0001; in_last = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stall_sel",   sel,      3);
      check("stall_ready", in_ready, 4'b0000);
      tick();
      check("stall_out_valid", out_valid, 0);
    end
    in_valid = 4'b1001; in_last = 4'b1001; d[3] = 32'hC4;
    #1;
    check("stall_last_ready", in_ready, 4'b1000);
    tick();
    check("stall_last_src",  out_src,  3);
    check("stall_last_data", out_data, 32'hC4);
    check("stall_last_last", out_last, 1);
    in_valid = 4'b0001;
    #1;
    check("stall_after_sel", sel, 0);
    tick();
    check("stall_after_src", out_src, 0);

    // Reset while locked on source 2 (ptr=1)
    in_valid = 4'b0100; in_last = 4'b0000; d[2] = 32'hD2;
    tick();
    check("mid_lock_src", out_src, 2);
    rst = 1'b1; in_valid = 4'b0110;
    tick();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data",  out_data,  0);
    rst = 1'b0;
    #1;
    check("mid_rst_sel",   sel,      1);
    check("mid_rst_ready", in_ready, 4'b0010);
    tick();
    check("mid_rst_grant", out_src, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
